uno_draw_pile: RTL and testbench

Parametrised UNO card store holding both the draw pile and the discard pile in one shared array of `N_DECKS*108` entries. It loads and shuffles N standard decks, serves multi-card draws with a valid/ready handshake, and accepts discards. When the draw pile runs dry it recycles the discard pile automatically, keeping the top discard face-up, and reshuffles. It sits between the game controller and the hand/player logic.

---
 rtl/uno_pkg.sv | 38 +++
 rtl/uno_card_rom.sv | 41 ++++
 rtl/uno_draw_pile.sv | 212 +++++++++++++++++++++
 tb/tb_uno_draw_pile.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uno_pkg.sv
// uno_pkg: card encoding, deck size and LFSR taps
// shared by the UNO draw/discard pile.
package uno_pkg;

  localparam int DECK_SIZE = 108;

  typedef enum logic [1:0] {
    RED, YELLOW, GREEN, BLUE
  } colour_e;

  typedef enum logic [3:0] {
    V0, V1, V2, V3, V4, V5, V6, V7, V8, V9,
    SKIP, REVERSE, DRAW_TWO, WILD, WILD_FOUR
  } value_e;

  typedef struct packed {
    colour_e colour;
    value_e  value;
  } card_t;

  // Fibonacci feedback mask, bit n-1 <-> x^n
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      default: return 32'h3 << (w - 2);
    endcase
  endfunction

endpackage

// File: rtl/uno_card_rom.sv
// uno_card_rom: index 0..107 to the card at that
// slot of one standard deck, 27 cards per colour.
module uno_card_rom
  import uno_pkg::*;
(
  input  logic [6:0] idx,
  output card_t      card
);

  logic [1:0] col;
  logic [6:0] base;
  logic [4:0] k;

  always_comb begin
    col  = 2'd3;
    base = 7'd81;
    if (idx < 7'd27) begin
      col  = 2'd0;
      base = 7'd0;
    end else if (idx < 7'd54) begin
      col  = 2'd1;
      base = 7'd27;
    end else if (idx < 7'd81) begin
      col  = 2'd2;
      base = 7'd54;
    end
    k = 5'(idx - base);
    card = '0;
    card.colour = colour_e'(col);
    // slot 0 single zero, 1..24 pairs of 1..12, then wilds
    if (k == 5'd0)
      card.value = V0;
    else if (k <= 5'd24)
      card.value = value_e'(4'((k + 5'd1) >> 1));
    else if (k == 5'd25)
      card.value = WILD;
    else
      card.value = WILD_FOUR;
  end

endmodule

// File: rtl/uno_draw_pile.sv
// uno_draw_pile: shared draw/discard card store with
// load, Fisher-Yates shuffle, draw and auto-recycle.
module uno_draw_pile
  import uno_pkg::*;
#(
  parameter int N_DECKS = 1,
  parameter int LFSR_W  = 8,
  localparam int DEPTH  = DECK_SIZE * N_DECKS,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_init,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_draw_req,
  input  logic [2:0]        i_draw_n,
  output logic              o_card_valid,
  output logic [5:0]        o_card,
  input  logic              i_card_ready,
  input  logic              i_discard_valid,
  input  logic [5:0]        i_discard_card,
  output logic              o_discard_ready,
  output logic              o_ready,
  output logic [CNT_W-1:0]  o_nd,
  output logic [CNT_W-1:0]  o_nx,
  output logic [5:0]        o_top_discard,
  output logic              o_short
);

  if (LFSR_W < IDX_W) begin : g_bad_lfsr_w
    $error("uno_draw_pile: LFSR_W must be >= IDX_W");
  end

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_SHUF = 3'd2;
  localparam logic [2:0] S_DRAW = 3'd3;
  localparam logic [2:0] S_FLIP = 3'd4;

  localparam logic [LFSR_W-1:0] TAPS =
    LFSR_W'(lfsr_taps(LFSR_W));
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
  localparam logic [6:0] ROM_LAST = 7'(DECK_SIZE - 1);

  logic [2:0]        state;
  logic [CNT_W-1:0]  nd, nx;
  logic [CNT_W-1:0]  nd_m1, nx_m1, nx_m2;
  logic              dir, from_flip;
  logic [2:0]        rem;
  logic [IDX_W-1:0]  idx, r;
  logic [6:0]        rom_idx;
  logic [LFSR_W-1:0] lfsr, lfsr_nxt;

  card_t mem [DEPTH];
  card_t rom_card, top_d, top_x, rd_i, rd_r;

  logic [IDX_W-1:0] pa, pb, p_top, p_xtop;
  logic [IDX_W-1:0] p_push, p_flip;
  logic draw_ok, space, hs, disc_we;
  logic swap_we, shuf_done;

  // dir flips which end of the array each pile grows from
  function automatic logic [IDX_W-1:0] dpos(
    input logic [IDX_W-1:0] i,
    input logic             d
  );
    return d ? LAST - i : i;
  endfunction

  function automatic logic [IDX_W-1:0] xpos(
    input logic [IDX_W-1:0] j,
    input logic             d
  );
    return d ? j : LAST - j;
  endfunction

  uno_card_rom u_rom (
    .idx  (rom_idx),
    .card (rom_card)
  );

  assign nd_m1 = nd - CNT_W'(1);
  assign nx_m1 = nx - CNT_W'(1);
  assign nx_m2 = nx - CNT_W'(2);

  assign r        = lfsr[IDX_W-1:0];
  assign lfsr_nxt = {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};

  assign p_top  = dpos(nd_m1[IDX_W-1:0], dir);
  assign p_xtop = xpos(nx_m1[IDX_W-1:0], dir);
  assign p_push = xpos(nx[IDX_W-1:0], dir);
  assign p_flip = xpos('0, ~dir);
  assign pa     = dpos(idx, dir);
  assign pb     = dpos(r, dir);

  assign top_d = mem[p_top];
  assign top_x = mem[p_xtop];
  assign rd_i  = mem[pa];
  assign rd_r  = mem[pb];

  assign space = ({1'b0, nd} + {1'b0, nx})
               < (CNT_W + 1)'(DEPTH);
  assign draw_ok = i_draw_req && i_draw_n != 3'd0
                && i_draw_n <= 3'd4;

  assign o_ready = state == S_IDLE;
  // init and draw win over a same-cycle discard
  assign o_discard_ready = o_ready && space
                        && !i_init && !draw_ok;
  assign disc_we = i_discard_valid && o_discard_ready;

  assign o_card_valid = state == S_DRAW && nd != '0;
  assign o_card = o_card_valid ? top_d : '0;
  assign hs = o_card_valid && i_card_ready;

  assign o_top_discard = (nx != '0) ? top_x : '0;
  assign o_short = state == S_DRAW && nd == '0
                && nx < CNT_W'(2);
  assign o_nd = nd;
  assign o_nx = nx;

  assign swap_we = state == S_SHUF && idx != '0
                && r <= idx;
  assign shuf_done = state == S_SHUF
    && (idx == '0 || (swap_we && idx == IDX_W'(1)));

  always_ff @(posedge i_clk) begin
    unique case (1'b1)
      state == S_LOAD: mem[idx] <= rom_card;
      swap_we: begin
        mem[pa] <= rd_r;
        mem[pb] <= rd_i;
      end
      state == S_FLIP: mem[p_flip] <= top_x;
      disc_we: mem[p_push] <= i_discard_card;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      nd        <= '0;
      nx        <= '0;
      dir       <= 1'b0;
      rem       <= '0;
      idx       <= '0;
      rom_idx   <= '0;
      from_flip <= 1'b0;
      lfsr      <= LFSR_W'(1);
    end else begin
      lfsr <= lfsr_nxt;
      case (state)
        S_IDLE: begin
          if (i_init) begin
            state   <= S_LOAD;
            nd      <= '0;
            nx      <= '0;
            dir     <= 1'b0;
            idx     <= '0;
            rom_idx <= '0;
            lfsr    <= (i_seed == '0) ? LFSR_W'(1)
                                      : i_seed;
          end else if (draw_ok) begin
            state <= S_DRAW;
            rem   <= i_draw_n;
          end else if (disc_we) begin
            nx <= nx + CNT_W'(1);
          end
        end
        S_LOAD: begin
          rom_idx <= (rom_idx == ROM_LAST) ? '0
                   : rom_idx + 7'd1;
          if (idx == LAST) begin
            nd        <= CNT_W'(DEPTH);
            from_flip <= 1'b0;
            state     <= S_SHUF;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        S_SHUF: begin
          if (shuf_done)
            state <= from_flip ? S_DRAW : S_IDLE;
          else if (swap_we)
            idx <= idx - IDX_W'(1);
        end
        S_DRAW: begin
          if (nd == '0) begin
            state <= (nx >= CNT_W'(2)) ? S_FLIP : S_IDLE;
          end else if (hs) begin
            nd  <= nd_m1;
            rem <= rem - 3'd1;
            if (rem == 3'd1)
              state <= S_IDLE;
          end
        end
        S_FLIP: begin
          dir       <= ~dir;
          nd        <= nx_m1;
          nx        <= CNT_W'(1);
          idx       <= nx_m2[IDX_W-1:0];
          from_flip <= 1'b1;
          state     <= S_SHUF;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uno_draw_pile.sv
// tb_uno_draw_pile: scoreboard bench for the UNO pile,
// one deck, 8-bit LFSR.
module tb_uno_draw_pile;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init = 1'b0;
  logic [7:0] seed = '0;
  logic       draw_req = 1'b0;
  logic [2:0] draw_n = '0;
  logic       card_ready = 1'b0;
  logic       disc_valid = 1'b0;
  logic [5:0] disc_card = '0;

  logic       card_valid, disc_ready, ready, short_p;
  logic [5:0] card, top_disc;
  logic [6:0] nd, nx;

  int n_checks = 0;
  int n_errs = 0;
  int n_short = 0;
  bit sb_on = 1'b0;

  logic [5:0] got_q[$];
  logic [5:0] exp_q[$];
  logic [5:0] seq1[$];
  logic [5:0] seq5a[$];
  logic [5:0] disc [5];

  uno_draw_pile #(.N_DECKS(1), .LFSR_W(8)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_init          (init),
    .i_seed          (seed),
    .i_draw_req      (draw_req),
    .i_draw_n        (draw_n),
    .o_card_valid    (card_valid),
    .o_card          (card),
    .i_card_ready    (card_ready),
    .i_discard_valid (disc_valid),
    .i_discard_card  (disc_card),
    .o_discard_ready (disc_ready),
    .o_ready         (ready),
    .o_nd            (nd),
    .o_nx            (nx),
    .o_top_discard   (top_disc),
    .o_short         (short_p)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (short_p) n_short++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] rom_ref(input int k);
    int c, j, v;
    c = k / 27;
    j = k % 27;
    if (j == 0) v = 0;
    else if (j <= 24) v = (j + 1) / 2;
    else v = j - 12;
    return 6'(c * 16 + v);
  endfunction

  function automatic bit in_first4(input logic [5:0] c);
    return c == disc[0] || c == disc[1]
        || c == disc[2] || c == disc[3];
  endfunction

  task automatic wait_ready();
    int c = 0;
    while (!ready && c < 5000) begin
      @(negedge clk);
      c++;
    end
    if (c >= 5000) chk("ready_timeout", ready, 1);
  endtask

  task automatic do_init(input logic [7:0] s);
    init = 1'b1;
    seed = s;
    @(negedge clk);
    init = 1'b0;
    wait_ready();
  endtask

  task automatic draw(input int n, input int stall_at,
                      input int stall_len, output int hs,
                      output int lat, output int v0);
    int st, cyc, last;
    logic [5:0] held;
    hs = 0; st = 0; cyc = 0; last = 0; held = '0;
    draw_req = 1'b1;
    draw_n = 3'(n);
    @(negedge clk);
    draw_req = 1'b0;
    draw_n = '0;
    v0 = int'(card_valid);
    while (!ready && cyc < 4000) begin
      card_ready = 1'b0;
      if (card_valid) begin
        if (hs == stall_at && st > 0)
          chk("hold", card, held);
        if (hs == stall_at && st < stall_len) begin
          if (st == 0) held = card;
          st++;
        end else begin
          card_ready = 1'b1;
          got_q.push_back(card);
          if (sb_on) begin
            chk("sb_avail", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0)
              chk("sb_card", card, exp_q.pop_front());
          end
          hs++;
          last = cyc;
        end
      end
      @(negedge clk);
      cyc++;
    end
    card_ready = 1'b0;
    if (cyc >= 4000) chk("draw_timeout", ready, 1);
    lat = cyc - last;
  endtask

  task automatic drain_to(input int keep);
    int hs, lat, v0, g, left;
    g = 0;
    while (int'(nd) > keep && g < 200) begin
      left = int'(nd) - keep;
      draw(left >= 4 ? 4 : left, -1, 0, hs, lat, v0);
      g++;
    end
  endtask

  task automatic push_discard(input logic [5:0] c);
    disc_valid = 1'b1;
    disc_card = c;
    chk("disc_rdy", disc_ready, 1);
    @(negedge clk);
    disc_valid = 1'b0;
  endtask

  initial begin
    int hs, lat, v0, same, sh0;
    int hist [64];
    disc[0] = 6'h01; disc[1] = 6'h12; disc[2] = 6'h23;
    disc[3] = 6'h34; disc[4] = 6'h0D;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_nd", nd, 0);
    chk("rst_nx", nx, 0);
    chk("rst_valid", card_valid, 0);
    chk("rst_card", card, 0);
    chk("rst_short", short_p, 0);
    chk("rst_top", top_disc, 0);
    chk("rst_drdy", disc_ready, 1);

    // seed 1 reference order
    do_init(8'h01);
    chk("init1_nd", nd, 108);
    chk("init1_nx", nx, 0);
    got_q.delete();
    drain_to(0);
    chk("drain1_n", got_q.size(), 108);
    seq1 = got_q;

    // seed 0 must behave as seed 1
    foreach (seq1[i]) exp_q.push_back(seq1[i]);
    sb_on = 1'b1;
    do_init(8'h00);
    got_q.delete();
    drain_to(0);
    sb_on = 1'b0;
    chk("sb0_left", exp_q.size(), 0);
    exp_q.delete();

    // seed 0x5A contents
    do_init(8'h5A);
    chk("init5a_nd", nd, 108);
    got_q.delete();
    drain_to(0);
    seq5a = got_q;
    chk("drain5a_n", seq5a.size(), 108);
    chk("drain5a_nd", nd, 0);
    foreach (hist[c]) hist[c] = 0;
    foreach (seq5a[i]) hist[seq5a[i]]++;
    for (int c = 0; c < 64; c++) begin
      int v, e;
      v = c % 16;
      if (v == 0 || v == 13 || v == 14) e = 1;
      else if (v <= 12) e = 2;
      else e = 0;
      chk($sformatf("hist_%0h", c), hist[c], e);
    end
    same = 0;
    foreach (seq5a[i]) if (seq5a[i] == rom_ref(107 - i)) same++;
    chk("shuffled", same == 108, 0);
    same = 0;
    foreach (seq5a[i]) if (seq5a[i] == seq1[i]) same++;
    chk("seed_diff", same == 108, 0);

    // same seed twice
    foreach (seq5a[i]) exp_q.push_back(seq5a[i]);
    sb_on = 1'b1;
    do_init(8'h5A);
    drain_to(0);
    sb_on = 1'b0;
    chk("sb5a_left", exp_q.size(), 0);
    exp_q.delete();

    // stalled 4-card draw
    do_init(8'h5A);
    for (int i = 0; i < 107; i++) exp_q.push_back(seq5a[i]);
    sb_on = 1'b1;
    draw(4, 1, 3, hs, lat, v0);
    chk("stall_hs", hs, 4);
    chk("stall_v0", v0, 1);
    chk("stall_lat", lat, 1);
    chk("stall_nd", nd, 104);
    chk("stall_rdy", ready, 1);

    // down to one card, then recycle 5 discards
    drain_to(1);
    sb_on = 1'b0;
    chk("pre_nd", nd, 1);
    chk("pre_sb", exp_q.size(), 0);
    for (int i = 0; i < 5; i++) push_discard(disc[i]);
    chk("pre_nx", nx, 5);
    chk("pre_top", top_disc, 6'h0D);
    sh0 = n_short;
    got_q.delete();
    draw(3, -1, 0, hs, lat, v0);
    chk("flip_hs", hs, 3);
    chk("flip_c0", got_q[0], seq5a[107]);
    chk("flip_c1", in_first4(got_q[1]), 1);
    chk("flip_c2", in_first4(got_q[2]), 1);
    chk("flip_dist", got_q[1] != got_q[2], 1);
    chk("flip_nd", nd, 2);
    chk("flip_nx", nx, 1);
    chk("flip_top", top_disc, 6'h0D);
    chk("flip_short", n_short - sh0, 0);

    draw(2, -1, 0, hs, lat, v0);
    chk("rest_hs", hs, 2);
    for (int i = 1; i < 5; i++)
      for (int j = i + 1; j < 5; j++)
        chk("rest_dist", got_q[i] != got_q[j], 1);
    chk("rest_c3", in_first4(got_q[3]), 1);
    chk("rest_c4", in_first4(got_q[4]), 1);
    chk("rest_nd", nd, 0);

    // empty draw with a lone discard
    draw(2, -1, 0, hs, lat, v0);
    chk("short_hs", hs, 0);
    chk("short_cnt", n_short - sh0, 1);
    chk("short_nd", nd, 0);
    chk("short_nx", nx, 1);
    chk("short_top", top_disc, 6'h0D);

    // full store refuses discards; bad n ignored
    do_init(8'h5A);
    chk("full_drdy", disc_ready, 0);
    disc_valid = 1'b1;
    disc_card = 6'h05;
    @(negedge clk);
    disc_valid = 1'b0;
    chk("full_nx", nx, 0);
    draw_req = 1'b1;
    draw_n = 3'd5;
    @(negedge clk);
    draw_req = 1'b0;
    chk("n5_ready", ready, 1);
    draw_req = 1'b1;
    draw_n = 3'd0;
    @(negedge clk);
    draw_req = 1'b0;
    chk("n0_ready", ready, 1);
    chk("nbad_nd", nd, 108);

    // reset in the middle of a shuffle
    init = 1'b1;
    seed = 8'h33;
    @(negedge clk);
    init = 1'b0;
    repeat (150) @(negedge clk);
    chk("busy", ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", ready, 1);
    chk("arst_nd", nd, 0);
    chk("arst_nx", nx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
